gpio_sw_debounce: RTL

Input-side conditioner for the board's slide/push switches (GPIO_SW), complementing the LED output path in the top level. Each asynchronous switch input is synchronized into the `clk` domain, debounced by a per-switch state machine, and presented as a clean level, single-cycle rise/fall event pulses, a press-toggled level and a wrapping press counter. The block sits directly behind the top-level `GPIO_SW` pins on the 100 MHz MMCM clock and feeds control logic and LEDs.

---
 rtl/gpio_sw_debounce.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gpio_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sw_debounce
// Brief    : Per-switch synchronizer + debounce FSM for GPIO_SW inputs.
//            Produces clean level, rise/fall pulses, press toggle and a
//            wrapping 8-bit press counter per switch.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_sw_debounce #(
  parameter int NUM_SW          = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SW-1:0]     sw_i,
  output logic [NUM_SW-1:0]     sw_o,
  output logic [NUM_SW-1:0]     rise_o,
  output logic [NUM_SW-1:0]     fall_o,
  output logic [NUM_SW-1:0]     toggle_o,
  output logic [8*NUM_SW-1:0]   press_cnt_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // Commit fires on the edge where the stable run reaches DEBOUNCE_CYCLES;
  // the counter already holds 1 when the WAIT state is entered.
  localparam logic [CW-1:0] c_last = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);
  localparam logic [CW-1:0] c_max  = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_t;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_lane
    (* ASYNC_REG = "TRUE" *) logic r_sync_head;
    logic [SYNC_STAGES-2:0] r_sync_tail;
    logic                   w_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_toggle;
    logic [7:0]             r_press;

    assign w_sync = r_sync_tail[SYNC_STAGES-2];

    // Synchronizer chain bringing the raw switch into the clk domain
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync_head <= 1'b0;
        r_sync_tail <= '0;
      end else begin
        r_sync_head    <= sw_i[i];
        r_sync_tail[0] <= r_sync_head;
        for (int k = 1; k < SYNC_STAGES - 1; k++) begin
          r_sync_tail[k] <= r_sync_tail[k-1];
        end
      end
    end

    // Debounce FSM; all outputs update on the commit edge
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state  <= ST_STABLE_LO;
        r_cnt    <= '0;
        r_level  <= 1'b0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_toggle <= 1'b0;
        r_press  <= 8'd0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        case (r_state)
          ST_STABLE_LO: begin
            if (w_sync) begin
              r_state <= ST_WAIT_HI;
              r_cnt   <= c_one;
            end
          end
          ST_WAIT_HI: begin
            if (!w_sync) begin
              r_state <= ST_STABLE_LO;
              r_cnt   <= '0;
            end else if (r_cnt >= c_last) begin
              r_state  <= ST_STABLE_HI;
              r_cnt    <= '0;
              r_level  <= 1'b1;
              r_rise   <= 1'b1;
              r_toggle <= ~r_toggle;
              r_press  <= r_press + 8'd1;
            end else if (r_cnt != c_max) begin
              r_cnt <= r_cnt + c_one;
            end
          end
          ST_STABLE_HI: begin
            if (!w_sync) begin
              r_state <= ST_WAIT_LO;
              r_cnt   <= c_one;
            end
          end
          ST_WAIT_LO: begin
            if (w_sync) begin
              r_state <= ST_STABLE_HI;
              r_cnt   <= '0;
            end else if (r_cnt >= c_last) begin
              r_state <= ST_STABLE_LO;
              r_cnt   <= '0;
              r_level <= 1'b0;
              r_fall  <= 1'b1;
            end else if (r_cnt != c_max) begin
              r_cnt <= r_cnt + c_one;
            end
          end
          default: begin
            r_state <= ST_STABLE_LO;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign sw_o[i]              = r_level;
    assign rise_o[i]            = r_rise;
    assign fall_o[i]            = r_fall;
    assign toggle_o[i]          = r_toggle;
    assign press_cnt_o[8*i +: 8] = r_press;
  end

endmodule
`default_nettype wire
